// File: rtl/branch_resolver.sv
// branch_resolver: latches comparator flags and resolves conditional branches into taken/next-PC results.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken result counters.
module branch_resolver #(
  parameter int ADDR_WIDTH   = 20,
  parameter int OFFSET_WIDTH = 12,
  parameter int PC_STEP      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmp_valid,
  input  logic                    lt,
  input  logic                    ge,
  input  logic                    br_valid,
  output logic                    br_ready,
  input  logic [1:0]              br_cond,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_taken,
  output logic [ADDR_WIDTH-1:0]   res_target,
  output logic                    flags_valid
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]             stat_taken,
  output logic [15:0]             stat_not_taken
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE} state_t;
  localparam logic [1:0] C_ALWAYS = 2'b00, C_LT = 2'b01, C_GE = 2'b10, C_NEVER = 2'b11;
  state_t state_q, state_d;
  logic lt_q, lt_d, ge_q, ge_d, flags_valid_q, flags_valid_d, taken_q, taken_d;
  logic [1:0] cond_q, cond_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, off_q, off_d, target_q, target_d, sext_off;
  logic hs;
  function automatic logic take(input logic [1:0] c, input logic l, input logic g);
    return c == C_ALWAYS ? 1'b1 : c == C_LT ? l : c == C_GE ? g : 1'b0;
  endfunction
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] p,
                                                    input logic [ADDR_WIDTH-1:0] o, input logic t);
    return t ? p + o : p + ADDR_WIDTH'(PC_STEP);
  endfunction
  assign sext_off    = {{(ADDR_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
  assign br_ready    = state_q == IDLE;
  assign res_valid   = state_q == RESOLVE;
  assign res_taken   = taken_q;
  assign res_target  = target_q;
  assign flags_valid = flags_valid_q;
  assign hs          = res_valid && res_ready;
  always_comb begin
    state_d       = state_q;
    lt_d          = cmp_valid ? lt : lt_q;
    ge_d          = cmp_valid ? ge : ge_q;
    flags_valid_d = flags_valid_q | cmp_valid;
    cond_d        = cond_q;
    pc_d          = pc_q;
    off_d         = off_q;
    taken_d       = taken_q;
    target_d      = target_q;
    if (state_q == IDLE && br_valid) begin
      cond_d = br_cond;
      pc_d   = pc;
      off_d  = sext_off;
      // lt_d/ge_d already carry the same-cycle compare, giving the bypass for free
      if (br_cond == C_ALWAYS || br_cond == C_NEVER || flags_valid_q || cmp_valid) begin
        state_d  = RESOLVE;
        taken_d  = take(br_cond, lt_d, ge_d);
        target_d = next_pc(pc, sext_off, taken_d);
      end else begin
        state_d = WAIT_FLAGS;
      end
    end else if (state_q == WAIT_FLAGS && cmp_valid) begin
      state_d  = RESOLVE;
      taken_d  = take(cond_q, lt, ge);
      target_d = next_pc(pc_q, off_q, taken_d);
    end else if (hs) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lt_q          <= 1'b0;
      ge_q          <= 1'b0;
      flags_valid_q <= 1'b0;
      cond_q        <= C_ALWAYS;
      pc_q          <= '0;
      off_q         <= '0;
      taken_q       <= 1'b0;
      target_q      <= '0;
    end else begin
      state_q       <= state_d;
      lt_q          <= lt_d;
      ge_q          <= ge_d;
      flags_valid_q <= flags_valid_d;
      cond_q        <= cond_d;
      pc_q          <= pc_d;
      off_q         <= off_d;
      taken_q       <= taken_d;
      target_q      <= target_d;
    end
  end
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken_q, stat_taken_d, stat_not_taken_q, stat_not_taken_d;
  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
  always_comb begin
    stat_taken_d     = (hs && taken_q && stat_taken_q != 16'hFFFF) ? stat_taken_q + 16'd1 : stat_taken_q;
    stat_not_taken_d = (hs && !taken_q && stat_not_taken_q != 16'hFFFF) ? stat_not_taken_q + 16'd1 : stat_not_taken_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else begin
      stat_taken_q     <= stat_taken_d;
      stat_not_taken_q <= stat_not_taken_d;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and randomized checks of branch_resolver against a flag/arithmetic model.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst = 1'b0, cmp_valid = 1'b0, lt = 1'b0, ge = 1'b0, br_valid = 1'b0, res_ready = 1'b0;
  logic [1:0] br_cond = 2'b00;
  logic [19:0] pc = '0;
  logic [11:0] offset = '0;
  logic br_ready, res_valid, res_taken, flags_valid;
  logic [19:0] res_target;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken, stat_not_taken;
`endif
  int total = 0, passed = 0;
  logic m_lt = 1'b0, m_ge = 1'b0, m_fv = 1'b0;

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .lt(lt), .ge(ge),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .pc(pc), .offset(offset),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .flags_valid(flags_valid)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
  );

  function automatic logic model_taken(input logic [1:0] c);
    case (c)
      2'd0: return 1'b1;
      2'd1: return m_lt;
      2'd2: return m_ge;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [19:0] model_target(input logic [19:0] p, input logic [11:0] o, input logic t);
    int so;
    so = int'($signed(o));
    return t ? 20'(int'(p) + so) : 20'(int'(p) + 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; br_valid = 1'b0; cmp_valid = 1'b0; res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_lt = 1'b0; m_ge = 1'b0; m_fv = 1'b0;
  endtask

  task automatic send_cmp(input logic l, input logic g);
    cmp_valid = 1'b1; lt = l; ge = g;
    step();
    cmp_valid = 1'b0;
    m_lt = l; m_ge = g; m_fv = 1'b1;
  endtask

  task automatic send_br(input logic [1:0] c, input logic [19:0] p, input logic [11:0] o);
    br_valid = 1'b1; br_cond = c; pc = p; offset = o;
    step();
    br_valid = 1'b0;
  endtask

  task automatic retire();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else passed++;
    total++; if (br_ready !== 1'b1) $display("FAIL reset_br_ready got %b want 1", br_ready); else passed++;
    total++; if (flags_valid !== 1'b0) $display("FAIL reset_flags_valid got %b want 0", flags_valid); else passed++;
    total++; if (res_target !== 20'h0) $display("FAIL reset_target got %h want 0", res_target); else passed++;
    total++; if (res_taken !== 1'b0) $display("FAIL reset_taken got %b want 0", res_taken); else passed++;
  endtask

  task automatic test_lt_taken();
    send_cmp(1'b1, 1'b0);
    total++; if (flags_valid !== 1'b1) $display("FAIL lt_flags_valid got %b want 1", flags_valid); else passed++;
    send_br(2'b01, 20'h00100, 12'hFFC);
    total++; if (res_valid !== 1'b1) $display("FAIL lt_res_valid got %b want 1", res_valid); else passed++;
    total++; if (res_taken !== 1'b1) $display("FAIL lt_taken got %b want 1", res_taken); else passed++;
    total++; if (res_target !== 20'h000FC) $display("FAIL lt_target got %h want 000fc", res_target); else passed++;
    total++; if (br_ready !== 1'b0) $display("FAIL lt_br_ready got %b want 0", br_ready); else passed++;
    retire();
    total++; if (res_valid !== 1'b0) $display("FAIL lt_retire got %b want 0", res_valid); else passed++;
  endtask

  task automatic test_ge();
    send_cmp(1'b0, 1'b1);
    send_br(2'b01, 20'h00100, 12'h010);
    total++; if (res_taken !== 1'b0) $display("FAIL ge_lt_taken got %b want 0", res_taken); else passed++;
    total++; if (res_target !== 20'h00104) $display("FAIL ge_lt_target got %h want 00104", res_target); else passed++;
    retire();
    send_br(2'b10, 20'h00100, 12'h010);
    total++; if (res_taken !== 1'b1) $display("FAIL ge_ge_taken got %b want 1", res_taken); else passed++;
    total++; if (res_target !== 20'h00110) $display("FAIL ge_ge_target got %h want 00110", res_target); else passed++;
    retire();
  endtask

  task automatic test_wait_and_hold();
    do_reset();
    send_br(2'b01, 20'h00200, 12'h020);
    for (int i = 0; i < 3; i++) begin
      total++; if (res_valid !== 1'b0) $display("FAIL wait_res_valid[%0d] got %b want 0", i, res_valid); else passed++;
      total++; if (br_ready !== 1'b0) $display("FAIL wait_br_ready[%0d] got %b want 0", i, br_ready); else passed++;
      if (i < 2) step();
    end
    send_cmp(1'b1, 1'b0);
    total++; if (res_valid !== 1'b1) $display("FAIL wait_done_valid got %b want 1", res_valid); else passed++;
    total++; if (res_taken !== 1'b1) $display("FAIL wait_done_taken got %b want 1", res_taken); else passed++;
    total++; if (res_target !== 20'h00220) $display("FAIL wait_done_target got %h want 00220", res_target); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) send_cmp(1'b0, 1'b1); else step();
      total++; if (res_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b want 1", i, res_valid); else passed++;
      total++; if (res_taken !== 1'b1) $display("FAIL hold_taken[%0d] got %b want 1", i, res_taken); else passed++;
      total++; if (res_target !== 20'h00220) $display("FAIL hold_target[%0d] got %h want 00220", i, res_target); else passed++;
      total++; if (br_ready !== 1'b0) $display("FAIL hold_br_ready[%0d] got %b want 0", i, br_ready); else passed++;
    end
    retire();
    total++; if (res_valid !== 1'b0) $display("FAIL hold_retire got %b want 0", res_valid); else passed++;
    send_br(2'b10, 20'h00300, 12'h008);
    total++; if (res_taken !== 1'b1) $display("FAIL hold_flags_ge_taken got %b want 1", res_taken); else passed++;
    total++; if (res_target !== 20'h00308) $display("FAIL hold_flags_ge_target got %h want 00308", res_target); else passed++;
    retire();
  endtask

  task automatic test_wrap_and_rst();
    send_br(2'b00, 20'hFFFFC, 12'h008);
    total++; if (res_target !== 20'h00004) $display("FAIL wrap_target got %h want 00004", res_target); else passed++;
    total++; if (res_valid !== 1'b1) $display("FAIL wrap_valid got %b want 1", res_valid); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_lt = 1'b0; m_ge = 1'b0; m_fv = 1'b0;
    total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid); else passed++;
    total++; if (br_ready !== 1'b1) $display("FAIL rst_br_ready got %b want 1", br_ready); else passed++;
    total++; if (flags_valid !== 1'b0) $display("FAIL rst_flags_valid got %b want 0", flags_valid); else passed++;
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic [19:0] p;
    logic [11:0] o;
    logic use_cmp, t;
    logic [19:0] tgt;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      c = 2'($urandom); p = 20'($urandom); o = 12'($urandom); use_cmp = 1'($urandom);
      total++; if (br_ready !== 1'b1) $display("FAIL rnd_br_ready[%0d] got %b want 1", n, br_ready); else passed++;
      br_valid = 1'b1; br_cond = c; pc = p; offset = o;
      cmp_valid = use_cmp; lt = 1'($urandom); ge = 1'($urandom);
      step();
      br_valid = 1'b0; cmp_valid = 1'b0;
      if (use_cmp) begin m_lt = lt; m_ge = ge; m_fv = 1'b1; end
      if ((c == 2'd1 || c == 2'd2) && !m_fv) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          total++; if (res_valid !== 1'b0) $display("FAIL rnd_wait[%0d] got %b want 0", n, res_valid); else passed++;
          step();
        end
        send_cmp(1'($urandom), 1'($urandom));
      end
      t = model_taken(c);
      tgt = model_target(p, o, t);
      for (int h = $urandom_range(0, 3); h >= 0; h--) begin
        total++; if (res_valid !== 1'b1) $display("FAIL rnd_valid[%0d] got %b want 1", n, res_valid); else passed++;
        total++; if (res_taken !== t) $display("FAIL rnd_taken[%0d] cond=%0d got %b want %b", n, c, res_taken, t); else passed++;
        total++; if (res_target !== tgt) $display("FAIL rnd_target[%0d] got %h want %h", n, res_target, tgt); else passed++;
        if (h > 0) begin
          if (1'($urandom)) send_cmp(1'($urandom), 1'($urandom)); else step();
        end
      end
      retire();
      total++; if (res_valid !== 1'b0) $display("FAIL rnd_retire[%0d] got %b want 0", n, res_valid); else passed++;
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_br(i < 3 ? 2'b00 : 2'b11, 20'h00400, 12'h010);
      retire();
    end
    total++; if (stat_taken !== 16'd3) $display("FAIL stat_taken got %0d want 3", stat_taken); else passed++;
    total++; if (stat_not_taken !== 16'd2) $display("FAIL stat_not_taken got %0d want 2", stat_not_taken); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_lt_taken();
    test_ge();
    test_wait_and_hold();
    test_wrap_and_rst();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
